// File: rtl/mips_single_cycle_core.sv
// Single-cycle MIPS-I subset core: fetch, decode, execute, memory access and
// writeback all complete within one clock. Instruction memory, data memory
// and the register bank are internal and are preloaded hierarchically while
// rst is held high.

module mips_instr_mem #(
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [31:0]              addr,
    output logic [31:0]              rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] regData [0:DEPTH-1];
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    // Optional loading port; the core keeps it idle so contents come only from preload
    always_ff @(posedge clk) begin
        if (we) regData[waddr] <= wdata;
    end

    assign rdata = regData[addr[AW+1:2]];
endmodule

module mips_data_mem #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] data_mem_ff [0:DEPTH-1];
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    // Word store; upper address bits alias so segment bases map onto index 0
    always_ff @(posedge clk) begin
        if (we) data_mem_ff[addr[AW+1:2]] <= wdata;
    end

    assign rdata = data_mem_ff[addr[AW+1:2]];
endmodule

module mips_reg_bank (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);
    logic [31:0] reg_file_ff [0:31];

    // Single write port; $0 is hardwired so writes to it are dropped
    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) reg_file_ff[waddr] <= wdata;
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : reg_file_ff[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : reg_file_ff[raddr_b];
endmodule

module mips_single_cycle_core #(
    parameter int IMEM_DEPTH     = 512,
    parameter int DATA_MEM_DEPTH = 1024
) (
    input logic clk,
    input logic rst
);
    logic [31:0] pc, hi, lo;
    logic [31:0] instr, pc_plus4, next_pc;
    logic [31:0] rs_val, rt_val, simm, zimm;
    logic [31:0] mem_addr, mem_rdata;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic        reg_we, mem_we, hilo_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [63:0] hilo_next, prod_signed, prod_unsigned;

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign simm     = {{16{instr[15]}}, instr[15:0]};
    assign zimm     = {16'd0, instr[15:0]};
    assign pc_plus4 = pc + 32'd4;
    assign mem_addr = rs_val + simm;

    assign prod_signed   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_unsigned = {32'd0, rs_val} * {32'd0, rt_val};

    mips_instr_mem #(.DEPTH(IMEM_DEPTH)) InstructionMemory (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata (32'd0),
        .addr  (pc),
        .rdata (instr)
    );

    mips_reg_bank RegBank (
        .clk     (clk),
        .we      (reg_we & ~rst),
        .waddr   (reg_waddr),
        .wdata   (reg_wdata),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_val),
        .rdata_b (rt_val)
    );

    mips_data_mem #(.DEPTH(DATA_MEM_DEPTH)) DataMemory (
        .clk   (clk),
        .we    (mem_we & ~rst),
        .addr  (mem_addr),
        .wdata (rt_val),
        .rdata (mem_rdata)
    );

    // Decode and execute; unknown encodings fall through with no side effects
    always_comb begin
        next_pc   = pc_plus4;
        reg_we    = 1'b0;
        reg_waddr = rd;
        reg_wdata = 32'd0;
        mem_we    = 1'b0;
        hilo_we   = 1'b0;
        hilo_next = 64'd0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: begin reg_we = 1'b1; reg_wdata = rs_val + rt_val; end
                    6'h22, 6'h23: begin reg_we = 1'b1; reg_wdata = rs_val - rt_val; end
                    6'h24: begin reg_we = 1'b1; reg_wdata = rs_val & rt_val; end
                    6'h25: begin reg_we = 1'b1; reg_wdata = rs_val | rt_val; end
                    6'h26: begin reg_we = 1'b1; reg_wdata = rs_val ^ rt_val; end
                    6'h27: begin reg_we = 1'b1; reg_wdata = ~(rs_val | rt_val); end
                    6'h2A: begin reg_we = 1'b1; reg_wdata = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
                    6'h2B: begin reg_we = 1'b1; reg_wdata = {31'd0, rs_val < rt_val}; end
                    6'h00: begin reg_we = 1'b1; reg_wdata = rt_val << shamt; end
                    6'h02: begin reg_we = 1'b1; reg_wdata = rt_val >> shamt; end
                    6'h03: begin reg_we = 1'b1; reg_wdata = $signed(rt_val) >>> shamt; end
                    6'h08: next_pc = rs_val;
                    6'h18: begin hilo_we = 1'b1; hilo_next = prod_signed; end
                    6'h19: begin hilo_we = 1'b1; hilo_next = prod_unsigned; end
                    6'h10: begin reg_we = 1'b1; reg_wdata = hi; end
                    6'h12: begin reg_we = 1'b1; reg_wdata = lo; end
                    default: ;
                endcase
            end
            6'h08, 6'h09: begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = rs_val + simm; end
            6'h0A: begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = {31'd0, $signed(rs_val) < $signed(simm)}; end
            6'h0B: begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = {31'd0, rs_val < simm}; end
            6'h0C: begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = rs_val & zimm; end
            6'h0D: begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = rs_val | zimm; end
            6'h0E: begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = rs_val ^ zimm; end
            6'h0F: begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = {instr[15:0], 16'd0}; end
            6'h23: begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = mem_rdata; end
            6'h2B: mem_we = 1'b1;
            6'h04: if (rs_val == rt_val) next_pc = pc_plus4 + {simm[29:0], 2'b00};
            6'h05: if (rs_val != rt_val) next_pc = pc_plus4 + {simm[29:0], 2'b00};
            6'h02: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            6'h03: begin
                next_pc   = {pc_plus4[31:28], instr[25:0], 2'b00};
                reg_we    = 1'b1;
                reg_waddr = 5'd31;
                reg_wdata = pc_plus4;
            end
            default: ;
        endcase
    end

    // Architectural PC and HI/LO; reset only touches these, not the memories
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 32'd0;
            hi <= 32'd0;
            lo <= 32'd0;
        end else begin
            pc <= next_pc;
            if (hilo_we) begin
                hi <= hilo_next[63:32];
                lo <= hilo_next[31:0];
            end
        end
    end
endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Bench for mips_single_cycle_core: an instruction-level interpreter runs in
// lockstep with the core and the architectural state is compared every cycle,
// with hand-computed literals pinning both the core and the interpreter.

module tb_mips_single_cycle_core;
    logic clk;
    logic rst;

    mips_single_cycle_core #(.IMEM_DEPTH(512), .DATA_MEM_DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    logic check_en;

    logic [31:0] prog [$];
    logic [31:0] m_imem [0:511];
    logic [31:0] m_dmem [0:1023];
    logic [31:0] m_reg  [0:31];
    logic [31:0] m_pc, m_hi, m_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pin(input string name, input logic [31:0] dut_val,
                       input logic [31:0] model_val, input logic [31:0] exp);
        check({name, " (core)"}, dut_val, exp);
        check({name, " (model)"}, model_val, exp);
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_reg[r] = v;
    endtask

    // One instruction of the ISA, applied to the interpreter state
    task automatic model_step();
        logic [31:0] ins, a, b, simm, zimm, p4, npc, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        ins  = m_imem[(m_pc >> 2) % 512];
        op   = ins[31:26];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        sh   = ins[10:6];
        fn   = ins[5:0];
        a    = m_reg[rs];
        b    = m_reg[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'd0, ins[15:0]};
        p4   = m_pc + 32'd4;
        npc  = p4;
        ea   = a + simm;
        case (op)
            6'h00: case (fn)
                6'h20, 6'h21: wr(rd, a + b);
                6'h22, 6'h23: wr(rd, a - b);
                6'h24: wr(rd, a & b);
                6'h25: wr(rd, a | b);
                6'h26: wr(rd, a ^ b);
                6'h27: wr(rd, ~(a | b));
                6'h2A: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                6'h2B: wr(rd, (a < b) ? 32'd1 : 32'd0);
                6'h00: wr(rd, b << sh);
                6'h02: wr(rd, b >> sh);
                6'h03: wr(rd, 32'($signed(b) >>> sh));
                6'h08: npc = a;
                6'h18: begin
                    sa = $signed(a);
                    sb = $signed(b);
                    sp = sa * sb;
                    m_hi = sp[63:32];
                    m_lo = sp[31:0];
                end
                6'h19: begin
                    ua = a;
                    ub = b;
                    up = ua * ub;
                    m_hi = up[63:32];
                    m_lo = up[31:0];
                end
                6'h10: wr(rd, m_hi);
                6'h12: wr(rd, m_lo);
                default: ;
            endcase
            6'h08, 6'h09: wr(rt, a + simm);
            6'h0A: wr(rt, ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0);
            6'h0B: wr(rt, (a < simm) ? 32'd1 : 32'd0);
            6'h0C: wr(rt, a & zimm);
            6'h0D: wr(rt, a | zimm);
            6'h0E: wr(rt, a ^ zimm);
            6'h0F: wr(rt, zimm << 16);
            6'h23: wr(rt, m_dmem[(ea >> 2) % 1024]);
            6'h2B: m_dmem[(ea >> 2) % 1024] = b;
            6'h04: if (a == b) npc = p4 + (simm << 2);
            6'h05: if (a != b) npc = p4 + (simm << 2);
            6'h02: npc = {p4[31:28], ins[25:0], 2'b00};
            6'h03: begin
                npc = {p4[31:28], ins[25:0], 2'b00};
                wr(5'd31, p4);
            end
            default: ;
        endcase
        m_pc = npc;
    endtask

    // Advance one clock edge, keeping the interpreter in step with the core
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_pc = 32'd0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else begin
            model_step();
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Hold reset, preload program and state into core and model, then release
    task automatic applyStimulus();
        check_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 512; i++) begin
            m_imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
            dut.InstructionMemory.regData[i] <= m_imem[i];
        end
        for (int i = 0; i < 1024; i++) begin
            m_dmem[i] = 32'd0;
            dut.DataMemory.data_mem_ff[i] <= 32'd0;
        end
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = (i == 31) ? 32'h1001_0000 : 32'd0;
            dut.RegBank.reg_file_ff[i] <= m_reg[i];
        end
        tick();
        check_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Lockstep comparison of all architectural state against the interpreter
    always @(negedge clk) begin
        if (check_en) begin
            int k;
            check("pc", dut.pc, m_pc);
            check("hi", dut.hi, m_hi);
            check("lo", dut.lo, m_lo);
            for (int i = 0; i < 32; i++)
                check($sformatf("reg%0d", i), dut.RegBank.reg_file_ff[i], m_reg[i]);
            k = 0;
            for (int i = 1023; i >= 0; i--)
                if (dut.DataMemory.data_mem_ff[i] !== m_dmem[i]) k = i;
            check($sformatf("dmem[%0d]", k), dut.DataMemory.data_mem_ff[k], m_dmem[k]);
        end
    end

    task automatic checkOutput(input string name, input int r, input logic [31:0] exp);
        pin(name, dut.RegBank.reg_file_ff[r], m_reg[r], exp);
    endtask

    initial begin
        rst         = 1'b1;
        check_en    = 1'b0;
        vectors     = 0;
        miscompares = 0;

        $display("[TB] multiply program");
        prog.delete();
        prog.push_back(32'h0000_0000);
        prog.push_back(32'h2001_000F);
        prog.push_back(32'h2002_0002);
        prog.push_back(32'h0022_0018);
        prog.push_back(32'h03E1_0018);
        prog.push_back(32'h0000_0018);
        applyStimulus();
        pin("reset pc", dut.pc, m_pc, 32'd0);
        ticks(3);
        checkOutput("t1 $1", 1, 32'd15);
        checkOutput("t1 $2", 2, 32'd2);
        tick();
        pin("t1 hi4", dut.hi, m_hi, 32'd0);
        pin("t1 lo4", dut.lo, m_lo, 32'd30);
        tick();
        pin("t1 hi5", dut.hi, m_hi, 32'd0);
        pin("t1 lo5", dut.lo, m_lo, 32'hF00F_0000);
        tick();
        pin("t1 hi6", dut.hi, m_hi, 32'd0);
        pin("t1 lo6", dut.lo, m_lo, 32'd0);
        ticks(2);
        pin("t1 pc8", dut.pc, m_pc, 32'h20);

        $display("[TB] store/load program");
        prog.delete();
        prog.push_back(i_op(6'h08, 5'd0, 5'd3, 16'h0055));
        prog.push_back(i_op(6'h2B, 5'd31, 5'd3, 16'h0004));
        prog.push_back(i_op(6'h23, 5'd31, 5'd4, 16'h0004));
        applyStimulus();
        ticks(3);
        pin("t2 dmem1", dut.DataMemory.data_mem_ff[1], m_dmem[1], 32'h55);
        checkOutput("t2 $4", 4, 32'h55);

        $display("[TB] branch program");
        prog.delete();
        prog.push_back(i_op(6'h08, 5'd0, 5'd5, 16'd7));
        prog.push_back(i_op(6'h08, 5'd0, 5'd6, 16'd7));
        prog.push_back(i_op(6'h04, 5'd5, 5'd6, 16'd2));
        prog.push_back(i_op(6'h08, 5'd0, 5'd7, 16'd1));
        prog.push_back(i_op(6'h08, 5'd0, 5'd8, 16'd1));
        prog.push_back(i_op(6'h05, 5'd5, 5'd6, 16'd2));
        prog.push_back(i_op(6'h08, 5'd0, 5'd9, 16'd3));
        applyStimulus();
        ticks(3);
        pin("t3 beq pc", dut.pc, m_pc, 32'h14);
        tick();
        pin("t3 bne pc", dut.pc, m_pc, 32'h18);
        tick();
        checkOutput("t3 $9", 9, 32'd3);
        checkOutput("t3 $7", 7, 32'd0);
        checkOutput("t3 $8", 8, 32'd0);

        $display("[TB] jump and link program");
        prog.delete();
        for (int i = 0; i < 4; i++) prog.push_back(32'h0);
        prog.push_back(j_op(6'h03, 26'd8));
        prog.push_back(i_op(6'h08, 5'd0, 5'd10, 16'd1));
        prog.push_back(32'h0);
        prog.push_back(32'h0);
        prog.push_back(r_op(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
        applyStimulus();
        ticks(5);
        pin("t4 jal pc", dut.pc, m_pc, 32'h20);
        checkOutput("t4 $31", 31, 32'h14);
        tick();
        pin("t4 jr pc", dut.pc, m_pc, 32'h14);
        tick();
        checkOutput("t4 $10", 10, 32'd1);

        $display("[TB] signed/unsigned multiply program");
        prog.delete();
        prog.push_back(i_op(6'h08, 5'd0, 5'd1, 16'hFFFF));
        prog.push_back(i_op(6'h08, 5'd0, 5'd2, 16'd2));
        prog.push_back(r_op(5'd1, 5'd2, 5'd0, 5'd0, 6'h18));
        prog.push_back(r_op(5'd0, 5'd0, 5'd3, 5'd0, 6'h10));
        prog.push_back(r_op(5'd0, 5'd0, 5'd4, 5'd0, 6'h12));
        prog.push_back(r_op(5'd1, 5'd2, 5'd0, 5'd0, 6'h19));
        prog.push_back(r_op(5'd0, 5'd0, 5'd5, 5'd0, 6'h10));
        prog.push_back(r_op(5'd0, 5'd0, 5'd6, 5'd0, 6'h12));
        prog.push_back(i_op(6'h08, 5'd0, 5'd0, 16'd5));
        applyStimulus();
        ticks(3);
        pin("t5 mult hi", dut.hi, m_hi, 32'hFFFF_FFFF);
        pin("t5 mult lo", dut.lo, m_lo, 32'hFFFF_FFFE);
        ticks(3);
        pin("t5 multu hi", dut.hi, m_hi, 32'h0000_0001);
        pin("t5 multu lo", dut.lo, m_lo, 32'hFFFF_FFFE);
        ticks(3);
        checkOutput("t5 $3", 3, 32'hFFFF_FFFF);
        checkOutput("t5 $4", 4, 32'hFFFF_FFFE);
        checkOutput("t5 $5", 5, 32'h0000_0001);
        checkOutput("t5 $6", 6, 32'hFFFF_FFFE);
        checkOutput("t5 $0", 0, 32'd0);

        $display("[TB] ALU and jump program");
        prog.delete();
        prog.push_back(i_op(6'h08, 5'd0, 5'd1, 16'h1234));
        prog.push_back(i_op(6'h0F, 5'd0, 5'd2, 16'h8000));
        prog.push_back(i_op(6'h0D, 5'd2, 5'd2, 16'h0F0F));
        prog.push_back(r_op(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        prog.push_back(r_op(5'd1, 5'd2, 5'd4, 5'd0, 6'h22));
        prog.push_back(r_op(5'd1, 5'd2, 5'd5, 5'd0, 6'h24));
        prog.push_back(r_op(5'd1, 5'd2, 5'd6, 5'd0, 6'h25));
        prog.push_back(r_op(5'd1, 5'd2, 5'd7, 5'd0, 6'h26));
        prog.push_back(r_op(5'd1, 5'd2, 5'd8, 5'd0, 6'h27));
        prog.push_back(r_op(5'd2, 5'd1, 5'd9, 5'd0, 6'h2A));
        prog.push_back(r_op(5'd2, 5'd1, 5'd10, 5'd0, 6'h2B));
        prog.push_back(r_op(5'd0, 5'd2, 5'd11, 5'd4, 6'h00));
        prog.push_back(r_op(5'd0, 5'd2, 5'd12, 5'd4, 6'h02));
        prog.push_back(r_op(5'd0, 5'd2, 5'd13, 5'd4, 6'h03));
        prog.push_back(i_op(6'h0A, 5'd2, 5'd14, 16'hFFFF));
        prog.push_back(i_op(6'h0B, 5'd1, 5'd15, 16'hFFFF));
        prog.push_back(i_op(6'h0C, 5'd2, 5'd16, 16'hFFFF));
        prog.push_back(i_op(6'h0E, 5'd1, 5'd17, 16'hFFFF));
        prog.push_back(i_op(6'h09, 5'd2, 5'd18, 16'h8000));
        prog.push_back(j_op(6'h02, 26'd21));
        prog.push_back(i_op(6'h08, 5'd0, 5'd19, 16'd1));
        prog.push_back(32'hFFFF_FFFF);
        prog.push_back(i_op(6'h08, 5'd0, 5'd20, 16'd9));
        applyStimulus();
        ticks(22);
        checkOutput("t6 add wrap", 3, 32'h8000_2143);
        checkOutput("t6 nor", 8, 32'h7FFF_E0C0);
        checkOutput("t6 slt", 9, 32'd1);
        checkOutput("t6 sltu", 10, 32'd0);
        checkOutput("t6 sra", 13, 32'hF800_00F0);
        checkOutput("t6 slti", 14, 32'd1);
        checkOutput("t6 sltiu", 15, 32'd1);
        checkOutput("t6 addiu", 18, 32'h7FFF_8F0F);
        checkOutput("t6 skipped", 19, 32'd0);
        checkOutput("t6 after unknown", 20, 32'd9);
        pin("t6 pc", dut.pc, m_pc, 32'h5C);

        $display("[TB] reset mid-program");
        prog.delete();
        prog.push_back(i_op(6'h08, 5'd0, 5'd3, 16'h0055));
        prog.push_back(i_op(6'h2B, 5'd31, 5'd3, 16'h0004));
        prog.push_back(r_op(5'd3, 5'd3, 5'd0, 5'd0, 6'h18));
        prog.push_back(i_op(6'h23, 5'd31, 5'd4, 16'h0004));
        applyStimulus();
        ticks(3);
        pin("t7 pc before", dut.pc, m_pc, 32'h0C);
        pin("t7 lo before", dut.lo, m_lo, 32'h1C39);
        @(negedge clk);
        rst = 1'b1;
        tick();
        pin("t7 pc reset", dut.pc, m_pc, 32'd0);
        pin("t7 hi reset", dut.hi, m_hi, 32'd0);
        pin("t7 lo reset", dut.lo, m_lo, 32'd0);
        checkOutput("t7 $3 kept", 3, 32'h55);
        checkOutput("t7 $4 untouched", 4, 32'd0);
        pin("t7 dmem kept", dut.DataMemory.data_mem_ff[1], m_dmem[1], 32'h55);
        @(negedge clk);
        rst = 1'b0;
        tick();
        pin("t7 pc restart", dut.pc, m_pc, 32'h4);
        ticks(2);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mips_single_cycle_core.md
Name: mips_single_cycle_core

Overview:
- Single-cycle 32-bit MIPS-I subset processor executing one instruction per clock.
- Self-contained core with four internal submodules:
  - instruction memory, instance InstructionMemory, word array regData
  - data memory, instance DataMemory, word array data_mem_ff
  - register bank, instance RegBank, array reg_file_ff[0:31]
  - HI/LO multiply registers
- Memories and registers are loaded hierarchically by the bench while rst is high, so those instance and array names are fixed.
- No external bus.

Parameters:
- IMEM_DEPTH, 512, instruction memory depth in 32-bit words.
- DATA_MEM_DEPTH, 1024, data memory depth in 32-bit words (power of two).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.

Behaviour:
- Reset: while rst=1 at a rising edge, PC<=0, HI<=0, LO<=0.
  - Register bank, instruction memory and data memory are not cleared, so contents preloaded during reset survive.
  - Reset mid-program restarts fetch at PC 0 on the next edge after release.
- Fetch: PC is a byte address. Instruction = regData[PC[10:2]], read combinationally. Default next PC = PC+4, wrapping modulo 2^32.
- Register bank: two asynchronous read ports and one synchronous write port. Register 0 always reads 0 and writes to it are discarded. Contents persist indefinitely.
- Data memory:
  - Word index = addr[log2(DATA_MEM_DEPTH)+1:2]; upper address bits are ignored, so 0x10010000 maps to index 0.
  - Reads are asynchronous; writes are synchronous. addr[1:0] is ignored.
- R-type (opcode 0) instructions:
  - add/addu (0x20/0x21), sub/subu (0x22/0x23): wrap on overflow, no trap.
  - and 0x24, or 0x25, xor 0x26, nor 0x27.
  - slt 0x2A (signed), sltu 0x2B (unsigned).
  - sll 0x00, srl 0x02, sra 0x03: shift amount from shamt.
  - jr 0x08: PC<=rs.
  - mult 0x18 (signed), multu 0x19 (unsigned): {HI,LO}<=rs*rt as a 64-bit product; no GPR write.
  - mfhi 0x10, mflo 0x12: rd<=HI or rd<=LO.
  - Writeback for R-type goes to rd.
- I-type instructions:
  - addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B: sign-extended immediate.
  - andi 0x0C, ori 0x0D, xori 0x0E: zero-extended immediate.
  - lui 0x0F: rt<=imm<<16.
  - lw 0x23, sw 0x2B: address = rs + sign-extended imm.
  - beq 0x04, bne 0x05: if taken, PC<=PC+4+(simm<<2).
  - Writeback for I-type goes to rt.
- J-type instructions, with target {PC+4[31:28], addr26, 2'b00}:
  - j 0x02.
  - jal 0x03: additionally writes $31<=PC+4.
- No branch delay slot.
- Word 0x00000000 (sll $0,$0,0) is a no-op.
- Unknown opcode/funct: no register, memory or HI/LO change; PC<=PC+4.
- Simultaneous read and write of the same register in one cycle: the read returns the old value; the new value is visible next cycle.
- Latency: every instruction completes in exactly one clock. Results are visible to the following instruction with no hazards.

Test Plan:
- Program, preload and result:
  - Words 0..5 = 00000000, 2001000F, 20020002, 00220018, 03E10018, 00000018; all other words 0.
  - Preload $31=0x10010000 with rst high, then release.
  - After the 3rd edge: $1=15, $2=2.
  - After the 4th edge: HI=0, LO=30.
  - After the 5th edge: HI=0, LO=0xF00F0000.
  - After the 6th edge: HI=LO=0. PC keeps advancing through no-ops.
- Store/load round trip:
  - Program: addi $3,$0,0x55; sw $3,4($31) with $31=0x10010000; lw $4,4($31).
  - Expect data_mem_ff[1]=0x55 and $4=0x55.
- Branch, taken and not taken:
  - beq on equal registers with offset 2 skips two instructions (their target registers unchanged).
  - bne on the same registers falls through to PC+4.
- Jump and link round trip:
  - jal from PC 0x10 to word 8 sets $31=0x14.
  - jr $31 at word 8 returns PC to 0x14.
- Signed and unsigned multiply:
  - mult -1*2 gives HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu on the same operands gives HI=0x00000001, LO=0xFFFFFFFE.
  - mfhi/mflo copy these into GPRs; an addi to $0 leaves $0=0.
- Reset mid-program:
  - Assert rst for one edge at PC 0x0C: PC=0 and HI=LO=0 afterwards.
  - GPRs and data memory retain their values.
